// File: rtl/alu_seq.sv
// Sequential ALU: registered logic/add/sub, iterative shift-add multiply and
// restoring divide into a HI/LO pair, under a start/busy/done handshake.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             div_zero,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d, dz_q, dz_d, done_q, done_d;

   logic [WIDTH:0]   add_s, sub_s, mul_sum;
   logic [WIDTH-1:0] div_rem, mul_wh, mul_wl, div_wh, div_wl;
   logic             div_ge;

   always_comb begin
      add_s   = {1'b0, a} + {1'b0, b};
      sub_s   = {1'b0, a} - {1'b0, b};
      // Working pair {wh,wl}: multiplier/dividend shifts through wl.
      mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : '0);
      mul_wh  = mul_sum[WIDTH:1];
      mul_wl  = {mul_sum[0], wl_q[WIDTH-1:1]};
      div_ge  = {wh_q, wl_q[WIDTH-1]} >= {1'b0, opnd_q};
      div_rem = {wh_q[WIDTH-2:0], wl_q[WIDTH-1]} - opnd_q;
      div_wh  = div_ge ? div_rem : {wh_q[WIDTH-2:0], wl_q[WIDTH-1]};
      div_wl  = {wl_q[WIDTH-2:0], div_ge};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      wh_d     = wh_q;
      wl_d     = wl_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      carry_d  = carry_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (funct)
                  3'b000: result_d = a & b;
                  3'b001: result_d = ~(a | b);
                  3'b010: begin
                     result_d = add_s[WIDTH-1:0];
                     carry_d  = add_s[WIDTH];
                  end
                  3'b011: begin
                     result_d = sub_s[WIDTH-1:0];
                     carry_d  = sub_s[WIDTH];
                  end
                  3'b100: begin
                     done_d  = 1'b0;
                     state_d = S_MUL;
                     cnt_d   = '0;
                     opnd_d  = a;
                     wh_d    = '0;
                     wl_d    = b;
                  end
                  3'b101: begin
                     done_d  = 1'b0;
                     state_d = S_DIV;
                     cnt_d   = '0;
                     opnd_d  = b;
                     wh_d    = '0;
                     wl_d    = a;
                  end
                  3'b110:  result_d = hi_q;
                  default: result_d = lo_q;
               endcase
            end
         end
         S_MUL: begin
            wh_d  = mul_wh;
            wl_d  = mul_wl;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               hi_d     = mul_wh;
               lo_d     = mul_wl;
               result_d = mul_wl;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            // A zero divisor never fails the trial subtract, so the quotient
            // fills with ones and the dividend shifts back out as remainder.
            wh_d  = div_wh;
            wl_d  = div_wl;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               hi_d     = div_wh;
               lo_d     = div_wl;
               result_d = div_wl;
               dz_d     = (opnd_q == '0);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         opnd_q   <= '0;
         wh_q     <= '0;
         wl_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         wh_q     <= wh_d;
         wl_q     <= wl_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
      end
   end

   assign result   = result_q;
   assign carry    = carry_q;
   assign div_zero = dz_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops,
// hand sequences for MUL/DIV, busy handshake and reset corner cases.
module tb_alu_seq;
   logic       clk = 1'b0;
   logic       rst, start;
   logic [2:0] funct;
   logic [7:0] a, b;
   logic [7:0] result;
   logic       carry, div_zero, busy, done;
   int         ncmp = 0;
   int         nerr = 0;

   localparam logic [2:0] F_AND = 3'b000, F_NOR = 3'b001, F_ADD = 3'b010,
      F_SUB = 3'b011, F_MUL = 3'b100, F_DIV = 3'b101, F_MFHI = 3'b110, F_MFLO = 3'b111;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
      .result(result), .carry(carry), .div_zero(div_zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] f;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       c;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic op1(input logic [2:0] f, input logic [7:0] xa, input logic [7:0] xb,
                      input logic [7:0] er, input string nm);
      @(negedge clk);
      start = 1'b1; funct = f; a = xa; b = xb;
      @(negedge clk);
      start = 1'b0;
      chk({nm, " result"}, result, er);
      chk({nm, " done"}, done, 1);
      chk({nm, " busy"}, busy, 0);
   endtask

   task automatic run_long(input logic [2:0] f, input logic [7:0] xa, input logic [7:0] xb,
                           input logic [7:0] er, input logic edz, input bit inj, input string nm);
      int n;
      @(negedge clk);
      start = 1'b1; funct = f; a = xa; b = xb;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         chk({nm, " done during busy"}, done, 0);
         if (inj && n == 2) begin
            start = 1'b1; funct = F_ADD; a = 8'd1; b = 8'd1;
         end else begin
            start = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({nm, " busy cycles"}, n, 8);
      chk({nm, " done"}, done, 1);
      chk({nm, " result"}, result, er);
      chk({nm, " div_zero"}, div_zero, edz);
      @(negedge clk);
      chk({nm, " done pulse width"}, done, 0);
   endtask

   initial begin
      tv[0] = '{F_AND, 8'h0F, 8'h3C, 8'h0C, 1'b0};
      tv[1] = '{F_NOR, 8'h0F, 8'h3C, 8'hC0, 1'b0};
      tv[2] = '{F_ADD, 8'd200, 8'd100, 8'h2C, 1'b1};
      tv[3] = '{F_AND, 8'h0F, 8'h3C, 8'h0C, 1'b1};
      tv[4] = '{F_SUB, 8'd5, 8'd7, 8'hFE, 1'b1};
      tv[5] = '{F_SUB, 8'd7, 8'd5, 8'h02, 1'b0};
      tv[6] = '{F_ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
      tv[7] = '{F_MFHI, 8'h12, 8'h34, 8'h00, 1'b1};
      tv[8] = '{F_MFLO, 8'h56, 8'h78, 8'h00, 1'b1};

      rst = 1'b1; start = 1'b0; funct = 3'b000; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset result", result, 0);
      chk("reset carry", carry, 0);
      chk("reset div_zero", div_zero, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      rst = 1'b0;

      // start held high: one single-cycle op completes every cycle
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         start = 1'b1; funct = tv[i].f; a = tv[i].a; b = tv[i].b;
         @(negedge clk);
         chk($sformatf("vec%0d result", i), result, tv[i].r);
         chk($sformatf("vec%0d carry", i), carry, tv[i].c);
         chk($sformatf("vec%0d done", i), done, 1);
         chk($sformatf("vec%0d busy", i), busy, 0);
      end
      start = 1'b0;
      @(negedge clk);
      chk("idle done", done, 0);
      chk("result holds", result, 8'h00);

      run_long(F_MUL, 8'd200, 8'd150, 8'h30, 1'b0, 1'b0, "mul");
      op1(F_MFHI, 8'h00, 8'h00, 8'h75, "mfhi mul");
      op1(F_MFLO, 8'h00, 8'h00, 8'h30, "mflo mul");
      op1(F_MFHI, 8'h00, 8'h00, 8'h75, "mfhi repeat");

      run_long(F_DIV, 8'd200, 8'd7, 8'h1C, 1'b0, 1'b0, "div");
      op1(F_MFHI, 8'h00, 8'h00, 8'h04, "mfhi div");
      op1(F_MFLO, 8'h00, 8'h00, 8'h1C, "mflo div");
      chk("carry held over div", carry, 1);

      run_long(F_DIV, 8'h55, 8'h00, 8'hFF, 1'b1, 1'b0, "div0");
      op1(F_MFHI, 8'h00, 8'h00, 8'h55, "mfhi div0");
      op1(F_MFLO, 8'h00, 8'h00, 8'hFF, "mflo div0");

      run_long(F_MUL, 8'd200, 8'd150, 8'h30, 1'b1, 1'b1, "mul inject");
      chk("carry unaffected by ignored add", carry, 1);
      op1(F_MFHI, 8'h00, 8'h00, 8'h75, "mfhi inject");
      op1(F_AND, 8'hF0, 8'hFF, 8'hF0, "and after mul");
      chk("div_zero held after and", div_zero, 1);

      // reset sampled on edge 3 of a multiply
      @(negedge clk);
      start = 1'b1; funct = F_MUL; a = 8'd200; b = 8'd150;
      @(negedge clk);
      start = 1'b0;
      chk("mul2 busy", busy, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort result", result, 0);
      chk("abort div_zero", div_zero, 0);
      @(negedge clk);
      chk("abort no late done", done, 0);
      op1(F_MFHI, 8'h00, 8'h00, 8'h00, "mfhi after abort");
      op1(F_MFLO, 8'h00, 8'h00, 8'h00, "mflo after abort");
      op1(F_ADD, 8'd1, 8'd1, 8'h02, "add after abort");

      // reset and start on the same edge: request dropped
      @(negedge clk);
      rst = 1'b1; start = 1'b1; funct = F_ADD; a = 8'd3; b = 8'd4;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst+start done", done, 0);
      chk("rst+start result", result, 0);
      chk("rst+start busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
